// File: rtl/bus_timer_pkg.sv
// bus_timer_pkg: register offsets, reset values and CTRL layout for the bus timer
package bus_timer_pkg;

    typedef enum logic [1:0] {
        TMR_COUNT = 2'd0,
        TMR_RATE  = 2'd1,
        TMR_CLR   = 2'd2,
        TMR_CTRL  = 2'd3
    } tmr_reg_e;

    localparam logic [7:0] RATE_RST = 8'd100;
    localparam int CTRL_IRQ_EN = 0;
    localparam int CTRL_OVERRUN = 1;

    function automatic logic [7:0] ctrl_word(input logic irq_en, input logic overrun);
        ctrl_word = '0;
        ctrl_word[CTRL_IRQ_EN] = irq_en;
        ctrl_word[CTRL_OVERRUN] = overrun;
    endfunction

endpackage

// File: rtl/bus_timer_tick_gen.sv
// tick_gen: prescaler producing a one-cycle TICK every TICK_CYCLES clocks
module tick_gen #(
    parameter int TICK_CYCLES = 50000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic CLR,
    output logic TICK
);

    localparam int W = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;

    logic [W-1:0] cnt;

    assign TICK = cnt == W'(TICK_CYCLES - 1);

    always_ff @(posedge CLK)
        cnt <= (RESET || CLR || TICK) ? '0 : cnt + W'(1);

endmodule

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped ms counter with programmable periodic interrupt on the 8-bit bus
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter int         TICK_CYCLES = 50000,
    parameter logic [7:0] BASE_ADDR   = 8'hF0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    inout  wire  [7:0] BUS_DATA,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK
);

    logic [7:0] off, count, rate, interval, rd_mux, rd_q;
    logic       hit, rd, wr, clr, rate_wr, ctrl_wr, tick, evt, fire, irq_en, overrun, drv;
    tmr_reg_e   sel;

    assign off = BUS_ADDR - BASE_ADDR;
    assign hit = off < 8'd4;
    assign sel = tmr_reg_e'(off[1:0]);
    assign rd = hit && !BUS_WE;
    assign wr = hit && BUS_WE;
    assign clr = wr && sel == TMR_CLR;
    assign rate_wr = wr && sel == TMR_RATE;
    assign ctrl_wr = wr && sel == TMR_CTRL;

    // A clear or RATE write restarts the interval, so it also suppresses any event due this cycle
    assign evt = tick && !clr && !rate_wr && rate != 8'd0 && interval == rate - 8'd1;
    assign fire = evt && irq_en;

    tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .CLK  (CLK),
        .RESET(RESET),
        .CLR  (clr),
        .TICK (tick)
    );

    always_comb
        rd_mux = sel == TMR_COUNT ? count : sel == TMR_RATE ? rate : ctrl_word(irq_en, overrun);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count <= '0;
            interval <= '0;
            rate <= RATE_RST;
            irq_en <= 1'b1;
            overrun <= 1'b0;
            BUS_INTERRUPT_RAISE <= 1'b0;
            drv <= 1'b0;
            rd_q <= '0;
        end else begin
            count <= clr ? 8'd0 : count + 8'(tick);
            interval <= (clr || rate_wr || evt) ? 8'd0 : interval + 8'(tick);
            if (rate_wr)
                rate <= BUS_DATA;
            if (ctrl_wr)
                irq_en <= BUS_DATA[CTRL_IRQ_EN];
            overrun <= (overrun && !(ctrl_wr && BUS_DATA[CTRL_OVERRUN])) ||
                       (fire && BUS_INTERRUPT_RAISE && !BUS_INTERRUPT_ACK);
            BUS_INTERRUPT_RAISE <= fire || (BUS_INTERRUPT_RAISE && !BUS_INTERRUPT_ACK);
            drv <= rd && sel != TMR_CLR;
            rd_q <= rd_mux;
        end
    end

    assign BUS_DATA = drv ? rd_q : 8'hzz;

endmodule
